retro_bram_arbiter: RTL

- Two-initiator arbiter placed directly upstream of a single-port, one-cycle BRAM target.
- Lets two requesters (e.g. CPU and video fetch) share one BRAM with round-robin fairness and optional bounded burst locking.
- Routes the target's registered read data back to the initiator that issued the read, with a per-port DataReady pulse.
- Request path to the target is combinational, so the BRAM's single-cycle access latency is preserved.

---
 rtl/retro_bram_arbiter.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/retro_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : retro_bram_arbiter
// Purpose  : Two-initiator arbiter in front of a single-port, one-cycle BRAM.
//            Round-robin fairness with optional bounded burst locking. The
//            request path to the BRAM is purely combinational, so the BRAM's
//            one-cycle latency is preserved. Registered read data is steered
//            back to the port that issued the read, with a DataReady pulse.
// Ports    : Clk, nReset          clock, async active-low reset
//            Access/Lock[1:0]     per-port request / burst-lock request
//            Write0/1, Address0/1, Din0/1   per-port request payload
//            Ready[1:0]           grant (request accepted when Access&Ready)
//            DataReady[1:0]       one-cycle read-data-valid pulse
//            Dout0/1              per-port read data, held between pulses
//            Tgt*                 BRAM-side access, write, address, data
// Revision : 1.0 - initial release
// ============================================================================
module retro_bram_arbiter #(
    parameter int ADDRESS_BUS_WIDTH = 12,
    parameter int DATA_BUS_WIDTH    = 1,
    parameter int MAX_LOCK_CYCLES   = 16
) (
    input  logic                          Clk,
    input  logic                          nReset,
    input  logic [1:0]                    Access,
    input  logic [1:0]                    Lock,
    input  logic [DATA_BUS_WIDTH-1:0]     Write0,
    input  logic [DATA_BUS_WIDTH-1:0]     Write1,
    input  logic [ADDRESS_BUS_WIDTH-1:0]  Address0,
    input  logic [ADDRESS_BUS_WIDTH-1:0]  Address1,
    input  logic [8*DATA_BUS_WIDTH-1:0]   Din0,
    input  logic [8*DATA_BUS_WIDTH-1:0]   Din1,
    output logic [1:0]                    Ready,
    output logic [1:0]                    DataReady,
    output logic [8*DATA_BUS_WIDTH-1:0]   Dout0,
    output logic [8*DATA_BUS_WIDTH-1:0]   Dout1,
    output logic                          TgtAccess,
    output logic [DATA_BUS_WIDTH-1:0]     TgtWrite,
    output logic [ADDRESS_BUS_WIDTH-1:0]  TgtAddress,
    output logic [8*DATA_BUS_WIDTH-1:0]   TgtDin,
    input  logic [8*DATA_BUS_WIDTH-1:0]   TgtDout
);

    localparam int         c_DW       = 8 * DATA_BUS_WIDTH;
    localparam logic [7:0] c_MAX_LOCK = 8'(MAX_LOCK_CYCLES);

    // Registered state
    logic             r_last_grant_q, w_last_grant_d;
    logic             r_lock_valid_q, w_lock_valid_d;
    logic             r_lock_owner_q, w_lock_owner_d;
    logic [7:0]       r_lock_count_q, w_lock_count_d;
    logic             r_pend_valid_q, w_pend_valid_d;
    logic             r_pend_port_q,  w_pend_port_d;
    logic [c_DW-1:0]  r_dout0_q,      w_dout0_d;
    logic [c_DW-1:0]  r_dout1_q,      w_dout1_d;

    // Combinational grant signals
    logic [1:0]                   w_grant;
    logic                         w_grant_any;
    logic                         w_grant_port;
    logic                         w_other_req;
    logic [DATA_BUS_WIDTH-1:0]    w_sel_write;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = 2'b00;
        case (Access)
            2'b01: w_grant = 2'b01;
            2'b10: w_grant = 2'b10;
            2'b11: begin
                if (r_lock_valid_q && (r_lock_count_q < c_MAX_LOCK)) begin
                    w_grant = r_lock_owner_q ? 2'b10 : 2'b01;
                end else begin
                    w_grant = r_last_grant_q ? 2'b01 : 2'b10;
                end
            end
            default: w_grant = 2'b00;
        endcase
        // No grant may escape while reset is held, even though the
        // request path is purely combinational.
        if (!nReset) begin
            w_grant = 2'b00;
        end
    end

    assign w_grant_any  = |w_grant;
    assign w_grant_port = w_grant[1];
    assign w_other_req  = w_grant_port ? Access[0] : Access[1];
    assign w_sel_write  = w_grant_port ? Write1 : Write0;

    // ------------------------------------------------------------------
    // Target mux
    // ------------------------------------------------------------------
    assign Ready      = w_grant;
    assign TgtAccess  = w_grant_any;
    assign TgtWrite   = w_grant_any ? w_sel_write : '0;
    assign TgtAddress = w_grant_any ? (w_grant_port ? Address1 : Address0) : '0;
    assign TgtDin     = w_grant_any ? (w_grant_port ? Din1 : Din0) : '0;

    // ------------------------------------------------------------------
    // Next-state: round-robin, lock tracking, pending read, data capture
    // ------------------------------------------------------------------
    always_comb begin
        w_last_grant_d = r_last_grant_q;
        w_lock_valid_d = r_lock_valid_q;
        w_lock_owner_d = r_lock_owner_q;
        w_lock_count_d = r_lock_count_q;
        w_pend_valid_d = 1'b0;
        w_pend_port_d  = r_pend_port_q;
        w_dout0_d      = r_dout0_q;
        w_dout1_d      = r_dout1_q;

        // Owner dropping its request ends the burst.
        if (r_lock_valid_q && !Access[r_lock_owner_q]) begin
            w_lock_valid_d = 1'b0;
            w_lock_count_d = 8'd0;
        end

        if (w_grant_any) begin
            w_last_grant_d = w_grant_port;
            w_pend_valid_d = (w_sel_write == '0);
            w_pend_port_d  = w_grant_port;

            if (Lock[w_grant_port]) begin
                w_lock_valid_d = 1'b1;
                w_lock_owner_d = w_grant_port;
                if (!w_other_req) begin
                    // Count only contended grants.
                    w_lock_count_d = 8'd0;
                end else if (r_lock_valid_q && (r_lock_owner_q == w_grant_port)) begin
                    w_lock_count_d = (r_lock_count_q == c_MAX_LOCK) ?
                                     c_MAX_LOCK : r_lock_count_q + 8'd1;
                end else begin
                    w_lock_count_d = 8'd1;
                end
            end else begin
                // A non-locking grant, including the one handed to the
                // other port at saturation, releases any existing lock.
                w_lock_valid_d = 1'b0;
                w_lock_count_d = 8'd0;
            end
        end

        if (DataReady[0]) begin
            w_dout0_d = TgtDout;
        end
        if (DataReady[1]) begin
            w_dout1_d = TgtDout;
        end
    end

    // ------------------------------------------------------------------
    // Read return: pulse and bypass in the cycle after a read grant
    // ------------------------------------------------------------------
    assign DataReady[0] = r_pend_valid_q && !r_pend_port_q;
    assign DataReady[1] = r_pend_valid_q &&  r_pend_port_q;
    assign Dout0        = DataReady[0] ? TgtDout : r_dout0_q;
    assign Dout1        = DataReady[1] ? TgtDout : r_dout1_q;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            r_last_grant_q <= 1'b1;
            r_lock_valid_q <= 1'b0;
            r_lock_owner_q <= 1'b0;
            r_lock_count_q <= 8'd0;
            r_pend_valid_q <= 1'b0;
            r_pend_port_q  <= 1'b0;
            r_dout0_q      <= '0;
            r_dout1_q      <= '0;
        end else begin
            r_last_grant_q <= w_last_grant_d;
            r_lock_valid_q <= w_lock_valid_d;
            r_lock_owner_q <= w_lock_owner_d;
            r_lock_count_q <= w_lock_count_d;
            r_pend_valid_q <= w_pend_valid_d;
            r_pend_port_q  <= w_pend_port_d;
            r_dout0_q      <= w_dout0_d;
            r_dout1_q      <= w_dout1_d;
        end
    end

endmodule
`default_nettype wire
